controller_onchip_tdpram: RTL and testbench
===========================================

# controller_onchip_tdpram

Parametrised true-dual-port on-chip RAM for the controller system, replacing fixed-size single-port program/data RAMs. It provides two independent Avalon-MM slave ports (A, B) sharing one inferred memory array, with configurable width, depth, and output registering. Reads are pipelined with an explicit `readdatavalid` and a fixed latency. Per-byte write collisions between the ports are resolved deterministically.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits; must be a multiple of 8
- `DEPTH`, 1024, number of words; need not be a power of 2
- `ADDR_W`, `$clog2(DEPTH)`, address width (derived; do not override)
- `OUT_REG`, 0, 1 adds an output register stage (read latency 2 instead of 1)
- `INIT_FILE`, "controller_onchip_tdpram.hex", memory init image; "" means no initialisation

Ports (x = a, b; one set per port):
- `clk` in 1: single system clock
- `reset_n` in 1: asynchronous assert, active-low reset
- `clken` in 1: global clock enable; when low the whole block holds state
- `chipselect_x` in 1: port select
- `read_x` in 1: read request
- `write_x` in 1: write request
- `address_x` in ADDR_W: word address
- `byteenable_x` in DATA_W/8: byte lanes for writes
- `writedata_x` in DATA_W: write data
- `readdata_x` out DATA_W: read data; valid only when `readdatavalid_x` is high
- `readdatavalid_x` out 1: one-cycle pulse per accepted read

## Operation
- A request is accepted on a rising edge where `clken` and `chipselect_x` are high and `read_x` or `write_x` is high. There is no `waitrequest`; every request is accepted.
- If `read_x` and `write_x` are both high on the same port, the write is performed and no read is issued (no `readdatavalid_x`).
- A write updates only the enabled byte lanes. An all-zero `byteenable` is a no-op.
- Write/write collision (same address, same cycle): merge per byte. Lanes enabled on A take A's data. Lanes enabled only on B take B's data.
- Read/write collision across ports (same address, same cycle): the read returns the old data. The new data is visible to reads issued in the next cycle.
- Out-of-range address (≥ DEPTH): writes are dropped. Reads return all zeros and still pulse `readdatavalid_x`.
- Reset:
  - `readdatavalid_a/b` = 0.
  - `readdata_a/b` = 0.
  - The read pipeline is flushed; in-flight reads are discarded and never produce a valid.
  - Memory contents are NOT cleared.
- `clken` low freezes the read pipeline. A pending valid stays pending and emerges after `clken` returns high.

## Timing
- A read accepted at edge N asserts `readdata_x` and `readdatavalid_x` after edge N+1+OUT_REG, lasting one cycle (counting only `clken`-high cycles).
- Back-to-back reads every cycle are supported at full throughput on both ports simultaneously.
- Write latency: data is committed at the accepting edge and is readable by a request accepted at the next edge.
- `reset_n` deassertion is synchronised by the system reset bridge upstream. The first accepted request is at the first edge with `reset_n` high.

## Configuration
- `CONTROLLER_ONCHIP_RAM_PARITY_EN`
- Defined:
  - Each byte stores an extra even-parity bit, computed on write.
  - Outputs `rd_err_a` and `rd_err_b` (1 bit each) are added. Each pulses together with `readdatavalid_x` when any byte of the returned word fails its parity check.
  - Out-of-range reads never flag an error.
  - Both outputs reset to 0.
- Undefined: no parity storage and no `rd_err_*` ports. Memory width is exactly DATA_W.

## Structure
- Package `controller_onchip_ram_pkg`:
  - read-latency function (`1 + OUT_REG`)
  - byte-count constant helper
  - even-parity function per byte
  - collision-merge function (A-priority byte mux)
- Sub-module `controller_onchip_ram_rdpipe`: per-port read pipeline holding the valid shift stage, optional output register, zeroing for out-of-range reads and parity check. Instantiated twice.
- The top level holds the memory array, write merge and INIT_FILE loading.

## Test plan
- Write 0xDEADBEEF to A@0x010 with byteenable 0xF, then read B@0x010 → 0xDEADBEEF with `readdatavalid_b` one edge later (OUT_REG=0), or two edges later (OUT_REG=1).
- Same-cycle writes A@0x020 (0x11111111, be 0x3) and B@0x020 (0x22222222, be 0xE) over a prior value of 0 → read returns 0x22221111.
- Word 0x030 holds 0xAAAAAAAA; write A@0x030 = 0x55555555 while reading B@0x030 in the same cycle → B returns 0xAAAAAAAA. A read on the next cycle returns 0x55555555.
- DEPTH=1000: write to address 1000 then read 1000 → readdata 0 with valid. Word 999 is unchanged.
- Issue 4 back-to-back reads on A with OUT_REG=1 and assert `reset_n` low after the second accept → no `readdatavalid_a` pulses after reset. Memory retains previously written values.
- With `CONTROLLER_ONCHIP_RAM_PARITY_EN`: force-flip one stored bit via hierarchical access, then read that word → `rd_err` is 1 coincident with valid. A clean word gives `rd_err` = 0.

Source files
------------

// File: rtl/controller_onchip_ram_pkg.sv
// controller_onchip_ram_pkg: shared helpers for the dual-port controller RAM.
// Build macro CONTROLLER_ONCHIP_RAM_PARITY_EN widens each stored byte lane
// by one even-parity bit.
package controller_onchip_ram_pkg;

    localparam int BYTE_W = 8;

`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
    // stored lane = {parity, data byte}
    localparam int LANE_W = BYTE_W + 1;
`else
    localparam int LANE_W = BYTE_W;
`endif

    // accept edge to output edge, in enabled clock edges
    function automatic int rd_latency(input int out_reg);
        return 1 + out_reg;
    endfunction

    function automatic int byte_count(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // parity bit that makes the 9-bit lane carry an even number of ones
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

    // same-address write/write: port A owns every lane it enables
    function automatic logic [BYTE_W-1:0] merge_byte(input logic             en_a,
                                                     input logic [BYTE_W-1:0] a,
                                                     input logic [BYTE_W-1:0] b);
        return en_a ? a : b;
    endfunction

endpackage

// File: rtl/controller_onchip_ram_rdpipe.sv
// controller_onchip_ram_rdpipe: per-port read pipeline. Carries the valid and
// out-of-range flags alongside the array read word, optionally adds one word
// register, zeroes out-of-range results and (with
// CONTROLLER_ONCHIP_RAM_PARITY_EN) checks lane parity.
module controller_onchip_ram_rdpipe
    import controller_onchip_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clken,
    input  logic                                rd_acc,
    input  logic                                rd_oor,
    input  logic [byte_count(DATA_W)*LANE_W-1:0] rd_word,
    output logic [DATA_W-1:0]                   readdata,
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
    output logic                                rd_err,
`endif
    output logic                                readdatavalid
);

    localparam int STAGES = rd_latency(OUT_REG);
    localparam int NB     = byte_count(DATA_W);
    localparam int MEM_W  = NB * LANE_W;

    logic [STAGES:0]   vld_pipe;
    logic [STAGES-1:0] oor_pipe;
    logic [MEM_W-1:0]  out_word;
    logic [DATA_W-1:0] word_data;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
    logic              word_bad;
`endif

    // read flags advance one stage per enabled edge; reset drops in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            oor_pipe <= '0;
        end else if (clken) begin
            vld_pipe    <= {vld_pipe[STAGES-1:0], rd_acc};
            oor_pipe[0] <= rd_oor;
            for (int i = 1; i < STAGES; i++) oor_pipe[i] <= oor_pipe[i-1];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [MEM_W-1:0] word_q;
            // extra word stage between the array read and the output register
            always_ff @(posedge clk) begin
                if (clken && vld_pipe[0]) word_q <= rd_word;
            end
            assign out_word = word_q;
        end else begin : g_noreg
            assign out_word = rd_word;
        end
    endgenerate

    // strip stored lanes back to data bytes and flag any lane with bad parity
    always_comb begin
        word_data = '0;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        word_bad  = 1'b0;
`endif
        for (int i = 0; i < NB; i++) begin
            word_data[i*BYTE_W +: BYTE_W] = out_word[i*LANE_W +: BYTE_W];
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
            if (out_word[i*LANE_W + BYTE_W] != byte_parity(out_word[i*LANE_W +: BYTE_W]))
                word_bad = 1'b1;
`endif
        end
    end

    // output register: data only moves for a real read; out-of-range reads give 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
            rd_err   <= 1'b0;
`endif
        end else if (clken) begin
            if (vld_pipe[STAGES-1])
                readdata <= oor_pipe[STAGES-1] ? '0 : word_data;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
            rd_err <= vld_pipe[STAGES-1] && !oor_pipe[STAGES-1] && word_bad;
`endif
        end
    end

    assign readdatavalid = vld_pipe[STAGES];

endmodule

// File: rtl/controller_onchip_tdpram.sv
// controller_onchip_tdpram: true-dual-port on-chip RAM with two Avalon-MM
// slave ports sharing one array. Fixed read latency 1+OUT_REG, per-byte
// A-priority merge on same-address writes, read-old-data across ports.
// Build macro CONTROLLER_ONCHIP_RAM_PARITY_EN adds per-byte parity storage
// and the rd_err_a / rd_err_b outputs.
module controller_onchip_tdpram
    import controller_onchip_ram_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter int    OUT_REG   = 0,
    parameter string INIT_FILE = "controller_onchip_tdpram.hex"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic                 chipselect_a,
    input  logic                 read_a,
    input  logic                 write_a,
    input  logic [ADDR_W-1:0]    address_a,
    input  logic [DATA_W/8-1:0]  byteenable_a,
    input  logic [DATA_W-1:0]    writedata_a,
    output logic [DATA_W-1:0]    readdata_a,
    output logic                 readdatavalid_a,
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
    output logic                 rd_err_a,
    output logic                 rd_err_b,
`endif
    input  logic                 chipselect_b,
    input  logic                 read_b,
    input  logic                 write_b,
    input  logic [ADDR_W-1:0]    address_b,
    input  logic [DATA_W/8-1:0]  byteenable_b,
    input  logic [DATA_W-1:0]    writedata_b,
    output logic [DATA_W-1:0]    readdata_b,
    output logic                 readdatavalid_b
);

    localparam int              NB      = byte_count(DATA_W);
    localparam int              MEM_W   = NB * LANE_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [MEM_W-1:0] mem [DEPTH];

    logic              oor_a, oor_b;
    logic              rd_acc_a, rd_acc_b;
    logic              wr_a, wr_b, wr_coll;
    logic [ADDR_W-1:0] rd_idx_a, rd_idx_b;
    logic [MEM_W-1:0]  rd_word_a, rd_word_b;

    // write wins over read on the same port; out-of-range writes are dropped
    assign oor_a    = {1'b0, address_a} >= DEPTH_V;
    assign oor_b    = {1'b0, address_b} >= DEPTH_V;
    assign rd_acc_a = clken & chipselect_a & read_a & ~write_a;
    assign rd_acc_b = clken & chipselect_b & read_b & ~write_b;
    assign wr_a     = clken & chipselect_a & write_a & ~oor_a;
    assign wr_b     = clken & chipselect_b & write_b & ~oor_b;
    assign wr_coll  = wr_a & wr_b & (address_a == address_b);
    // out-of-range reads still index a legal word; the pipeline zeroes the result
    assign rd_idx_a = oor_a ? '0 : address_a;
    assign rd_idx_b = oor_b ? '0 : address_b;

    function automatic logic [LANE_W-1:0] enc_lane(input logic [BYTE_W-1:0] d);
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        return {byte_parity(d), d};
`else
        return d;
`endif
    endfunction

    // byte-lane writes; a same-address pair collapses into one merged write
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_coll) begin
                if (byteenable_a[i] || byteenable_b[i])
                    mem[address_a][i*LANE_W +: LANE_W] <=
                        enc_lane(merge_byte(byteenable_a[i],
                                            writedata_a[i*BYTE_W +: BYTE_W],
                                            writedata_b[i*BYTE_W +: BYTE_W]));
            end else begin
                if (wr_a && byteenable_a[i])
                    mem[address_a][i*LANE_W +: LANE_W] <= enc_lane(writedata_a[i*BYTE_W +: BYTE_W]);
                if (wr_b && byteenable_b[i])
                    mem[address_b][i*LANE_W +: LANE_W] <= enc_lane(writedata_b[i*BYTE_W +: BYTE_W]);
            end
        end
    end

    // port A array read; captures pre-write contents on the accepting edge
    always_ff @(posedge clk) begin
        if (rd_acc_a) rd_word_a <= mem[rd_idx_a];
    end

    // port B array read; captures pre-write contents on the accepting edge
    always_ff @(posedge clk) begin
        if (rd_acc_b) rd_word_b <= mem[rd_idx_b];
    end

    controller_onchip_ram_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .rd_acc        (rd_acc_a),
        .rd_oor        (oor_a),
        .rd_word       (rd_word_a),
        .readdata      (readdata_a),
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        .rd_err        (rd_err_a),
`endif
        .readdatavalid (readdatavalid_a)
    );

    controller_onchip_ram_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .rd_acc        (rd_acc_b),
        .rd_oor        (oor_b),
        .rd_word       (rd_word_b),
        .readdata      (readdata_b),
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        .rd_err        (rd_err_b),
`endif
        .readdatavalid (readdatavalid_b)
    );

endmodule

// File: tb/tb_controller_onchip_tdpram.sv
// Bench for controller_onchip_tdpram (DEPTH=1000, OUT_REG=1): a word-array
// model predicts every read; a negedge monitor compares each cycle, and
// directed reads pin the model with literal values.
module tb_controller_onchip_tdpram;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 1000;
    localparam int ADDR_W  = 10;
    localparam int OUT_REG = 1;
    localparam int LAT     = 1 + OUT_REG;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clken = 1'b1;
    logic              cs_a = 0, rd_a = 0, wr_a = 0, cs_b = 0, rd_b = 0, wr_b = 0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic [3:0]        be_a = '0, be_b = '0;
    logic [31:0]       wd_a = '0, wd_b = '0;
    logic [31:0]       rdata_a, rdata_b;
    logic              rdv_a, rdv_b;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
    logic              err_a, err_b;
`endif

    int checks = 0;
    int failures = 0;

    // model state
    logic [31:0] mm [DEPTH];
    bit          bad [DEPTH];
    int          ecount = 0;
    bit          ea_v [int];
    bit          eb_v [int];
    logic [31:0] ea_d [int];
    logic [31:0] eb_d [int];
    bit          ea_e [int];
    bit          eb_e [int];

    always #5 clk = ~clk;

    controller_onchip_tdpram #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .chipselect_a(cs_a), .read_a(rd_a), .write_a(wr_a), .address_a(addr_a),
        .byteenable_a(be_a), .writedata_a(wd_a), .readdata_a(rdata_a),
        .readdatavalid_a(rdv_a),
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        .rd_err_a(err_a), .rd_err_b(err_b),
`endif
        .chipselect_b(cs_b), .read_b(rd_b), .write_b(wr_b), .address_b(addr_b),
        .byteenable_b(be_b), .writedata_b(wd_b), .readdata_b(rdata_b),
        .readdatavalid_b(rdv_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_wr(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) mm[a][i*8 +: 8] = d[i*8 +: 8];
        if (be[0]) bad[a] = 1'b0;
    endtask

    // model: reads see the array before this edge's writes; B applied first so A wins overlaps
    always @(posedge clk) begin
        if (reset_n && clken) begin
            ecount++;
            if (cs_a && rd_a && !wr_a) begin
                ea_v[ecount+LAT] = 1'b1;
                ea_d[ecount+LAT] = (addr_a < DEPTH) ? mm[addr_a] : 32'h0;
                ea_e[ecount+LAT] = (addr_a < DEPTH) && bad[addr_a];
            end
            if (cs_b && rd_b && !wr_b) begin
                eb_v[ecount+LAT] = 1'b1;
                eb_d[ecount+LAT] = (addr_b < DEPTH) ? mm[addr_b] : 32'h0;
                eb_e[ecount+LAT] = (addr_b < DEPTH) && bad[addr_b];
            end
            if (cs_b && wr_b && addr_b < DEPTH) apply_wr(addr_b, be_b, wd_b);
            if (cs_a && wr_a && addr_a < DEPTH) apply_wr(addr_a, be_a, wd_a);
        end
    end

    // monitor: every cycle, compare against the model's prediction
    always @(negedge clk) begin
        if (!reset_n) begin
            ea_v.delete(); eb_v.delete();
            chk("rst_vld_a", {31'b0, rdv_a}, 32'h0);
            chk("rst_vld_b", {31'b0, rdv_b}, 32'h0);
            chk("rst_data_a", rdata_a, 32'h0);
            chk("rst_data_b", rdata_b, 32'h0);
        end else begin
            chk("mon_vld_a", {31'b0, rdv_a}, {31'b0, ea_v.exists(ecount)});
            chk("mon_vld_b", {31'b0, rdv_b}, {31'b0, eb_v.exists(ecount)});
            if (ea_v.exists(ecount)) chk("mon_data_a", rdata_a, ea_d[ecount]);
            if (eb_v.exists(ecount)) chk("mon_data_b", rdata_b, eb_d[ecount]);
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
            chk("mon_err_a", {31'b0, err_a}, {31'b0, ea_v.exists(ecount) && ea_e[ecount]});
            chk("mon_err_b", {31'b0, err_b}, {31'b0, eb_v.exists(ecount) && eb_e[ecount]});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit cs, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
        if (!p) begin
            cs_a = cs; rd_a = rd; wr_a = wr; addr_a = a; be_a = be; wd_a = d;
        end else begin
            cs_b = cs; rd_b = rd; wr_b = wr; addr_b = a; be_b = be; wd_b = d;
        end
    endtask

    task automatic wr(input bit p, input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
        set_req(p, 1, 0, 1, a, be, d);
        step();
        set_req(p, 0, 0, 0, '0, '0, '0);
    endtask

    // single read with literal expectations on latency, data and error flag
    task automatic rd_lit(input bit p, input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                          input bit exp_err, input string name);
        int lat;
        logic [31:0] d;
        logic e;
        set_req(p, 1, 1, 0, a, '0, '0);
        step();
        set_req(p, 0, 0, 0, '0, '0, '0);
        lat = -1;
        d = 'x;
        e = 1'bx;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (p ? rdv_b : rdv_a) begin
                lat = i;
                d = p ? rdata_b : rdata_a;
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
                e = p ? err_b : err_a;
`else
                e = 1'b0;
`endif
            end
        end
        chk({name, "_lat"}, lat, LAT);
        chk(name, d, exp);
`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        chk({name, "_err"}, {31'b0, e}, {31'b0, exp_err});
`else
        if (exp_err) chk({name, "_err"}, {31'b0, e}, 32'h1);
`endif
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = int'($urandom % 16);
        if (r == 0) return ADDR_W'(DEPTH + int'($urandom % 24));
        if (r < 5)  return ADDR_W'($urandom % 8);
        return ADDR_W'($urandom % DEPTH);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // fill every word so the model never predicts unknown data
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_req(0, 1, 0, 1, ADDR_W'(2*i), 4'hF, $urandom);
            set_req(1, 1, 0, 1, ADDR_W'(2*i + 1), 4'hF, $urandom);
            step();
        end
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);

        // A writes, B reads back
        wr(0, 10'h010, 4'hF, 32'hDEADBEEF);
        rd_lit(1, 10'h010, 32'hDEADBEEF, 0, "a_wr_b_rd");

        // same-cycle merge over a zero word
        wr(0, 10'h020, 4'hF, 32'h0);
        set_req(0, 1, 0, 1, 10'h020, 4'h3, 32'h11111111);
        set_req(1, 1, 0, 1, 10'h020, 4'hE, 32'h22222222);
        step();
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);
        rd_lit(0, 10'h020, 32'h22221111, 0, "ww_merge");

        // read-during-write across ports returns old data, next read new data
        wr(0, 10'h030, 4'hF, 32'hAAAAAAAA);
        set_req(0, 1, 0, 1, 10'h030, 4'hF, 32'h55555555);
        set_req(1, 1, 1, 0, 10'h030, '0, '0);
        step();
        set_req(0, 0, 0, 0, '0, '0, '0);
        step();
        set_req(1, 0, 0, 0, '0, '0, '0);
        for (int i = 1; i <= LAT + 2; i++) begin
            @(negedge clk);
            if (i == LAT) begin
                chk("rw_old_vld", {31'b0, rdv_b}, 32'h1);
                chk("rw_old_data", rdata_b, 32'hAAAAAAAA);
            end
            if (i == LAT + 1) begin
                chk("rw_new_vld", {31'b0, rdv_b}, 32'h1);
                chk("rw_new_data", rdata_b, 32'h55555555);
            end
        end

        // out-of-range write dropped, read returns zero with a valid
        wr(1, 10'd999, 4'hF, 32'h09990999);
        wr(0, 10'd1000, 4'hF, 32'hFFFFFFFF);
        rd_lit(0, 10'd1000, 32'h0, 0, "oor_rd");
        rd_lit(1, 10'd999, 32'h09990999, 0, "oor_neighbour");

        // clken stall: result still appears after LAT enabled edges
        set_req(0, 1, 1, 0, 10'h010, '0, '0);
        step();
        set_req(0, 0, 0, 0, '0, '0, '0);
        clken = 1'b0;
        repeat (3) step();
        clken = 1'b1;
        repeat (LAT) step();
        chk("stall_vld", {31'b0, rdv_a}, 32'h1);
        chk("stall_data", rdata_a, 32'hDEADBEEF);

        // reset in the middle of back-to-back reads flushes them
        wr(0, 10'h040, 4'hF, 32'hCAFEF00D);
        set_req(0, 1, 1, 0, 10'h040, '0, '0);
        step();
        set_req(0, 1, 1, 0, 10'h041, '0, '0);
        step();
        reset_n = 1'b0;
        set_req(0, 0, 0, 0, '0, '0, '0);
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_flush", {31'b0, rdv_a}, 32'h0);
        end
        rd_lit(0, 10'h040, 32'hCAFEF00D, 0, "rst_keep_mem");

`ifdef CONTROLLER_ONCHIP_RAM_PARITY_EN
        wr(0, 10'h050, 4'hF, 32'h12345678);
        step();
        dut.mem[10'h050][0] = ~dut.mem[10'h050][0];
        mm[10'h050] = mm[10'h050] ^ 32'h1;
        bad[10'h050] = 1'b1;
        rd_lit(0, 10'h050, 32'h12345679, 1, "par_bad");
        rd_lit(1, 10'h010, 32'hDEADBEEF, 0, "par_clean");
`endif

        // random traffic on both ports, checked by the monitor
        for (int n = 0; n < 3000; n++) begin
            clken = ($urandom % 8) != 0;
            set_req(0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
                    rand_addr(), 4'($urandom), $urandom);
            set_req(1, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
                    rand_addr(), 4'($urandom), $urandom);
            step();
        end
        clken = 1'b1;
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
